// File: rtl/mem_axi_bridge.sv
// ---------------------------------------------------------------------------
// mem_axi_bridge
// Turns a level-style load/store request from the memory stage into a single
// AXI4-Lite read or write transaction. It returns a one-cycle completion pulse
// with read data and an error flag. At most one transaction is in flight.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   request_enable, mode      request level (re-armed by a low cycle), 0=read 1=write
//   addr, wdata, wstrb        request address / store data / byte lanes
//   response_enable           one-cycle completion pulse
//   data, bus_error           read data (0 after a write), non-OKAY response flag
//   aw*, w*, b*               AXI4-Lite write address / data / response channels
//   ar*, r*                   AXI4-Lite read address / data channels
//
// State  | meaning
// IDLE   | waiting for an armed request
// WRITE  | AW and W valids outstanding (each completes on its own)
// WRESP  | bready high, waiting for bvalid
// READ   | arvalid high, waiting for arready
// RDATA  | rready high, waiting for rvalid
// ---------------------------------------------------------------------------
module mem_axi_bridge #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        response_enable,
    output logic [31:0] data,
    output logic        bus_error,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA
    } state_t;

    state_t      state_q;
    logic        armed_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        resp_en_q;
    logic        bus_err_q;
    logic [31:0] data_q;
    logic [31:0] awaddr_q;
    logic [31:0] araddr_q;
    logic [31:0] m_wdata_q;
    logic [3:0]  m_wstrb_q;

    // A channel is still pending if its valid is up and this cycle is not its
    // handshake; WRESP may be entered as soon as neither channel is pending.
    logic aw_pending;
    logic w_pending;
    assign aw_pending = awvalid_q && !awready;
    assign w_pending  = wvalid_q && !wready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            resp_en_q <= 1'b0;
            bus_err_q <= 1'b0;
            data_q    <= 32'h0;
            awaddr_q  <= 32'h0;
            araddr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            m_wstrb_q <= 4'h0;
        end else begin
            resp_en_q <= 1'b0;
            bus_err_q <= 1'b0;
            // A request level held across completion must drop before the
            // next one is taken.
            if (!request_enable) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (request_enable && armed_q) begin
                        armed_q <= 1'b0;
                        if (mode) begin
                            state_q   <= WRITE;
                            awaddr_q  <= addr;
                            m_wdata_q <= wdata;
                            m_wstrb_q <= wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= READ;
                            araddr_q  <= addr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (!aw_pending && !w_pending) begin
                        state_q  <= WRESP;
                        bready_q <= 1'b1;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        state_q   <= IDLE;
                        bready_q  <= 1'b0;
                        resp_en_q <= 1'b1;
                        bus_err_q <= (bresp != 2'b00);
                        data_q    <= 32'h0;
                    end
                end
                READ: begin
                    if (arready) begin
                        state_q   <= RDATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        state_q   <= IDLE;
                        rready_q  <= 1'b0;
                        resp_en_q <= 1'b1;
                        bus_err_q <= (rresp != 2'b00);
                        data_q    <= rdata;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign response_enable = resp_en_q;
    assign bus_error       = bus_err_q;
    assign data            = data_q;
    assign awvalid         = awvalid_q;
    assign awaddr          = awaddr_q;
    assign awprot          = PROT;
    assign wvalid          = wvalid_q;
    assign m_wdata         = m_wdata_q;
    assign m_wstrb         = m_wstrb_q;
    assign bready          = bready_q;
    assign arvalid         = arvalid_q;
    assign araddr          = araddr_q;
    assign arprot          = PROT;
    assign rready          = rready_q;

endmodule
